// File: rtl/comparador_serial_id.sv
// Bit-serial MSB-first unsigned magnitude comparator: walks two K-bit words over K
// cycles, producing the M/N decision chain one bit per clock, then pulses done with Z/E.
module comparador_serial_id #(
    parameter int K = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [K-1:0]         A,
    input  logic [K-1:0]         B,
    output logic                 busy,
    output logic                 done,
    output logic                 M,
    output logic                 N,
    output logic                 Z,
    output logic                 E,
    output logic [$clog2(K)-1:0] idx
);

    localparam int IW = $clog2(K);
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [K-1:0]    sa_q, sa_d;
    logic [K-1:0]    sb_q, sb_d;
    logic            m_q, m_d;
    logic            n_q, n_d;
    logic            z_q, z_d;
    logic            e_q, e_d;
    logic [IW-1:0]   idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            m_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            e_q     <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            m_q     <= m_d;
            n_q     <= n_d;
            z_q     <= z_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        m_d     = m_q;
        n_d     = n_q;
        z_d     = z_q;
        e_d     = e_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    m_d     = 1'b0;
                    n_d     = 1'b0;
                    z_d     = 1'b0;
                    e_d     = 1'b0;
                    idx_d   = LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Once a differing bit has decided the order, the flags freeze.
                if (!m_q && !n_q) begin
                    m_d = sa_q[K-1] & ~sb_q[K-1];
                    n_d = ~sa_q[K-1] & sb_q[K-1];
                end
                sa_d = {sa_q[K-2:0], 1'b0};
                sb_d = {sb_q[K-2:0], 1'b0};
                if (idx_q == '0) begin
                    z_d     = m_d;
                    e_d     = ~m_d & ~n_d;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign M    = m_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign E    = e_q;
    assign idx  = idx_q;

endmodule
